w_sched_ctrl: RTL and testbench
===============================

Name: w_sched_ctrl

Overview:
- Sequencer that drives the W-generator for one 512-bit message block per start command.
- Raises the W-generator's go signal and waits for its ready. Issues the 64 W reads in order (addresses 0..63) and captures each returned W.
- Presents each W to the compression round engine with its round index and the matching K constant, over a valid/ready handshake.
- Drops go at end of block so the W-generator returns to idle. Sits between the top-level block controller and the round engine.

Parameters:
- RD_LAT, 2, cycles from read pulse to W data valid at w_data_in (generator input register plus output register).
- RDY_TIMEOUT, 255, max cycles waiting for w_rdy_in after go before flagging error.
- GAP_CYCLES, 2, cycles go is held low after a block before blk_done pulses (lets the generator pass S3 to S0).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- blk_start  in  1  one-cycle pulse: a new padded block is stable at the generator's pad input
- abort  in  1  one-cycle pulse: terminate current block
- w_go_out  out  1  go to W-generator
- w_rdy_in  in  1  W-generator ready
- w_read_out  out  1  one-cycle read pulse
- w_addr_out  out  6  W index being read
- w_data_in  in  32  W data from generator
- round_valid  out  1  W/K pair valid to round engine
- round_ready  in  1  round engine accepts
- round_w  out  32  W[t]
- round_k  out  32  K[t]
- round_idx  out  6  t
- round_last  out  1  high with t=63
- busy  out  1  block in progress
- blk_done  out  1  one-cycle pulse after all 64 handed off and gap elapsed
- err_timeout  out  1  sticky until next blk_start or reset

Behaviour:
- Reset values: all outputs 0. FSM state IDLE, index counter 0, latency counter 0.
- Reset is sampled synchronously and has priority over all other inputs. Reset mid-block drops w_go_out next cycle; the generator then returns to idle via its own path.
- States:
  - IDLE: on blk_start, clear err_timeout and idx, then go to GO.
  - GO: w_go_out=1. Wait for w_rdy_in=1, then go to ISSUE. If the wait counter reaches RDY_TIMEOUT, set err_timeout and go to DRAIN.
  - ISSUE: w_read_out=1 for exactly one cycle with w_addr_out=idx, then go to WAIT. Only one read is outstanding at a time; this is mandatory because the generator advances its serving pointer per read.
  - WAIT: count RD_LAT cycles. On the terminal count, capture w_data_in into the output register, set round_w, round_idx=idx, round_k=K[idx], round_last=(idx==63), round_valid=1, then go to HOLD.
  - HOLD: hold outputs stable while round_valid=1 && round_ready=0. When round_ready=1, drop round_valid next cycle. If idx==63 go to DRAIN; else idx+1 and go to ISSUE.
  - DRAIN: w_go_out=0 for GAP_CYCLES cycles, pulse blk_done (not on timeout or abort), then go to IDLE.
- w_go_out is high continuously from GO through HOLD.
- w_addr_out holds idx in all states, not only in ISSUE.
- Throughput is at most one W per RD_LAT+2 cycles with round_ready held high. Idle-ready to first round_valid is 1 (ISSUE) + RD_LAT cycles after w_rdy_in is seen.
- idx is 6 bits and must not wrap. The 63 to DRAIN transition takes precedence over increment.
- blk_start while busy=1 is ignored.
- abort in any non-IDLE state: round_valid=0 next cycle, then go to DRAIN with no blk_done. An abort arriving in the same cycle as a round_ready handshake still counts as abort. The handshake completes, but no further reads are issued.
- busy=1 in all states except IDLE.
- K is a 64x32 constant lookup indexed by idx and registered alongside round_w.

Decomposition:
- Shared package sha256_pkg: the 64 K constants (K_TABLE), state encodings, W_COUNT=64.
- One sub-module, sha256_k_rom: 6-bit address in, 32-bit K out, combinational case. Reusable by the compression core.

Test Plan:
- "abc" block (W0=0x61626380, W15=0x00000018) with round_ready=1, against the real generator: 64 round_valid beats. idx=0 gives W=0x61626380, K=0x428A2F98. idx=16 gives W=0x61626380. idx=17 gives W=0x000F0000. idx=63 gives K=0xC67178F2 with round_last=1. blk_done pulses once. Full sequence is checked against a software W model.
- Backpressure: round_ready low for 5 cycles at idx=10. round_w/round_k/round_idx stay stable and no w_read_out occurs. After release, idx=11 follows correctly and the total count stays 64.
- Timeout: hold w_rdy_in=0 after blk_start. After 255 cycles err_timeout=1, w_go_out=0, no blk_done, busy returns to 0.
- Abort at idx=30 during HOLD: round_valid drops, no reads issued afterwards, no blk_done. A following blk_start runs a clean block where idx=0 W matches the new pad word 0.
- Reset asserted at idx=40: next cycle all outputs are 0. A new block then completes correctly against the model.
- Back-to-back blocks: blk_start again one cycle after blk_done. The second block yields 64 correct W/K beats; a blk_start issued while busy is ignored.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, schedule length and the
// state encoding of the W-schedule sequencer.
package sha256_pkg;

  localparam int W_COUNT = 64;
  localparam int IDX_W   = 6;
  localparam int DATA_W  = 32;
  localparam int COEF_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GO    = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DRAIN = 3'd5
  } sched_state_e;

  localparam logic [COEF_W-1:0] K_TABLE [W_COUNT] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round constant lookup: 6-bit round index in, K[t] out, purely
// combinational so the caller decides where to register it.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [IDX_W-1:0]  addr,
  output logic [COEF_W-1:0] k
);

  always_comb begin
    k = '0;
    case (addr)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
  end

endmodule

// File: rtl/w_sched_ctrl.sv
// Sequences one 512-bit block through the W-generator: go/ready, 64 in-order
// single-outstanding reads, and a W/K/t valid-ready stream to the round engine.
module w_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int RD_LAT      = 2,
  parameter int RDY_TIMEOUT = 255,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              blk_start,
  input  logic              abort,
  output logic              w_go_out,
  input  logic              w_rdy_in,
  output logic              w_read_out,
  output logic [IDX_W-1:0]  w_addr_out,
  input  logic [DATA_W-1:0] w_data_in,
  output logic              round_valid,
  input  logic              round_ready,
  output logic [DATA_W-1:0] round_w,
  output logic [COEF_W-1:0] round_k,
  output logic [IDX_W-1:0]  round_idx,
  output logic              round_last,
  output logic              busy,
  output logic              blk_done,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(RDY_TIMEOUT + RD_LAT + GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W_COUNT - 1);

  sched_state_e      state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              no_done;
  logic [COEF_W-1:0] k_p0;

  sha256_k_rom u_k_rom (
    .addr (idx),
    .k    (k_p0)
  );

  assign w_addr_out = idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      no_done     <= 1'b0;
      w_go_out    <= 1'b0;
      w_read_out  <= 1'b0;
      round_valid <= 1'b0;
      round_w     <= '0;
      round_k     <= '0;
      round_idx   <= '0;
      round_last  <= 1'b0;
      busy        <= 1'b0;
      blk_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      w_read_out <= 1'b0;
      blk_done   <= 1'b0;
      if (abort && state != ST_IDLE) begin
        // Abort wins over a coincident handshake; the gap still runs so the
        // generator sees go low long enough to return to idle.
        state       <= ST_DRAIN;
        round_valid <= 1'b0;
        w_go_out    <= 1'b0;
        no_done     <= 1'b1;
        if (state != ST_DRAIN) cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (blk_start) begin
              err_timeout <= 1'b0;
              idx         <= '0;
              cnt         <= '0;
              no_done     <= 1'b0;
              busy        <= 1'b1;
              w_go_out    <= 1'b1;
              state       <= ST_GO;
            end
          end
          ST_GO: begin
            if (w_rdy_in) begin
              w_read_out <= 1'b1;
              cnt        <= '0;
              state      <= ST_ISSUE;
            end else if (cnt == TO_LAST) begin
              err_timeout <= 1'b1;
              w_go_out    <= 1'b0;
              no_done     <= 1'b1;
              cnt         <= '0;
              state       <= ST_DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_ISSUE: begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            // Terminal count lands on the cycle the generator's output register holds W[idx].
            if (cnt == LAT_LAST) begin
              round_w     <= w_data_in;
              round_k     <= k_p0;
              round_idx   <= idx;
              round_last  <= (idx == IDX_LAST);
              round_valid <= 1'b1;
              state       <= ST_HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_HOLD: begin
            if (round_ready) begin
              round_valid <= 1'b0;
              if (idx == IDX_LAST) begin
                w_go_out <= 1'b0;
                cnt      <= '0;
                state    <= ST_DRAIN;
              end else begin
                idx        <= idx + 1'b1;
                w_read_out <= 1'b1;
                state      <= ST_ISSUE;
              end
            end
          end
          ST_DRAIN: begin
            if (cnt == GAP_LAST) begin
              blk_done <= ~no_done;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            w_go_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_w_sched_ctrl.sv
// Scoreboard bench for w_sched_ctrl with a behavioural W-generator model.
module tb_w_sched_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        blk_start = 1'b0;
  logic        abort = 1'b0;
  logic        w_go_out;
  logic        w_rdy_in = 1'b0;
  logic        w_read_out;
  logic [5:0]  w_addr_out;
  logic [31:0] w_data_in = 32'h0;
  logic        round_valid;
  logic        round_ready = 1'b0;
  logic [31:0] round_w;
  logic [31:0] round_k;
  logic [5:0]  round_idx;
  logic        round_last;
  logic        busy;
  logic        blk_done;
  logic        err_timeout;

  always #5 clock = ~clock;

  w_sched_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .blk_start   (blk_start),
    .abort       (abort),
    .w_go_out    (w_go_out),
    .w_rdy_in    (w_rdy_in),
    .w_read_out  (w_read_out),
    .w_addr_out  (w_addr_out),
    .w_data_in   (w_data_in),
    .round_valid (round_valid),
    .round_ready (round_ready),
    .round_w     (round_w),
    .round_k     (round_k),
    .round_idx   (round_idx),
    .round_last  (round_last),
    .busy        (busy),
    .blk_done    (blk_done),
    .err_timeout (err_timeout)
  );

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  idx;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] wmem [64];
  logic [31:0] pad  [16];
  bit          hold_rdy = 1'b0;
  int          rdy_cnt = 0;
  int          ptr = 0;
  bit          rd_a = 1'b0, rd_b = 1'b0;
  logic [5:0]  addr_a = '0, addr_b = '0;
  int          reads_total = 0;
  int          stall_idx = -1;
  int          stall_left = 0;
  int          stall_cycles = 0;
  int          beats = 0;
  int          done_cnt = 0;
  logic [31:0] got_w [64];
  logic [31:0] got_k [64];
  bit          got_last [64];
  logic [31:0] snap_w, snap_k;
  logic [5:0]  snap_idx;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // W-generator model: ready 3 cycles after go, data 2 cycles after a read, junk otherwise
  always @(negedge clock) begin
    bit pending;
    pending = rd_a || rd_b;
    w_data_in = rd_b ? wmem[addr_b] : 32'hDEAD_BEEF;
    rd_b = rd_a;
    addr_b = addr_a;
    rd_a = w_read_out;
    addr_a = w_addr_out;
    if (w_read_out) begin
      reads_total++;
      check((w_addr_out == 6'(ptr)) && !pending, "read_order", 32'(w_addr_out), 32'(ptr));
      ptr++;
    end
    if (!w_go_out) begin
      rdy_cnt = 0;
      ptr = 0;
      w_rdy_in = 1'b0;
    end else if (!hold_rdy) begin
      if (rdy_cnt < 3) rdy_cnt++;
      w_rdy_in = (rdy_cnt >= 3);
    end
  end

  // Ready policy and scoreboard monitor
  always @(negedge clock) begin
    beat_t e;
    if (blk_done) done_cnt++;
    if (round_valid && int'(round_idx) == stall_idx && stall_left > 0) begin
      if (round_ready) begin
        snap_w = round_w;
        snap_k = round_k;
        snap_idx = round_idx;
      end else begin
        check(round_w == snap_w && round_k == snap_k && round_idx == snap_idx && !w_read_out,
              "stall_stable", round_w, snap_w);
      end
      round_ready = 1'b0;
      stall_left--;
      stall_cycles++;
    end else begin
      round_ready = 1'b1;
    end
    if (round_valid && round_ready) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_beat", 32'(round_idx), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check(round_w == e.w, $sformatf("beat_w idx%0d", e.idx), round_w, e.w);
        check(round_k == e.k, $sformatf("beat_k idx%0d", e.idx), round_k, e.k);
        check({round_last, round_idx} == {e.last, e.idx}, $sformatf("beat_idx idx%0d", e.idx),
              32'({round_last, round_idx}), 32'({e.last, e.idx}));
      end
      got_w[round_idx] = round_w;
      got_k[round_idx] = round_k;
      got_last[round_idx] = round_last;
      beats++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_pad(input int sel);
    for (int i = 0; i < 16; i++) begin
      if (sel == 0) pad[i] = 32'h0;
      else pad[i] = {8'(sel), 8'(i), 16'hA5C3};
    end
    if (sel == 0) begin
      pad[0] = 32'h61626380;
      pad[15] = 32'h00000018;
    end
    for (int t = 0; t < 16; t++) wmem[t] = pad[t];
    for (int t = 16; t < 64; t++)
      wmem[t] = sig1(wmem[t-2]) + wmem[t-7] + sig0(wmem[t-15]) + wmem[t-16];
  endtask

  task automatic start_block(input int sel, input int n_exp);
    set_pad(sel);
    for (int t = 0; t < n_exp; t++)
      exp_q.push_back('{w: wmem[t], k: K_REF[t], idx: 6'(t), last: (t == 63)});
    blk_start = 1'b1;
    tick(1);
    blk_start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    check(n < limit, name, 32'(n), 32'(limit));
  endtask

  task automatic wait_beat(input int idx, input int limit, input string name);
    int n = 0;
    while (!(round_valid && int'(round_idx) == idx) && n < limit) begin
      tick(1);
      n++;
    end
    check(n < limit, name, 32'(n), 32'(limit));
  endtask

  task automatic check_zero(input string name);
    bit ok;
    ok = ({w_go_out, w_read_out, w_addr_out, round_valid, round_w, round_k, round_idx,
           round_last, busy, blk_done, err_timeout} == '0);
    check(ok, name, round_w | round_k | 32'({w_go_out, w_read_out, w_addr_out, round_valid,
          round_idx, round_last, busy, blk_done, err_timeout}), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0", 1);
    $fatal(1);
  end

  initial begin
    int d0, n, rd0;
    tick(3);
    check_zero("reset_outputs");
    reset = 1'b0;
    tick(1);

    // "abc" block, ready always high
    beats = 0; d0 = done_cnt;
    start_block(0, 64);
    check(busy && w_go_out, "busy_go_after_start", 32'({busy, w_go_out}), 32'h3);
    wait_idle(600, "abc_complete");
    tick(2);
    check(beats == 64, "abc_beats", 32'(beats), 32'd64);
    check(done_cnt - d0 == 1, "abc_blk_done", 32'(done_cnt - d0), 32'd1);
    check(exp_q.size() == 0, "abc_queue_empty", 32'(exp_q.size()), 32'd0);
    check(got_w[0] == 32'h61626380, "abc_w0", got_w[0], 32'h61626380);
    check(got_k[0] == 32'h428A2F98, "abc_k0", got_k[0], 32'h428A2F98);
    check(got_w[16] == 32'h61626380, "abc_w16", got_w[16], 32'h61626380);
    check(got_w[17] == 32'h000F0000, "abc_w17", got_w[17], 32'h000F0000);
    check(got_k[63] == 32'hC67178F2, "abc_k63", got_k[63], 32'hC67178F2);
    check(got_last[63] && !got_last[62], "abc_last", 32'({got_last[63], got_last[62]}), 32'h2);

    // Backpressure: ready low for 5 cycles at idx 10
    beats = 0; d0 = done_cnt; stall_cycles = 0;
    stall_idx = 10; stall_left = 5;
    start_block(1, 64);
    wait_idle(600, "bp_complete");
    tick(2);
    check(stall_cycles == 5, "bp_stall_cycles", 32'(stall_cycles), 32'd5);
    check(beats == 64, "bp_beats", 32'(beats), 32'd64);
    check(done_cnt - d0 == 1, "bp_blk_done", 32'(done_cnt - d0), 32'd1);
    check(exp_q.size() == 0, "bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ready never arrives
    hold_rdy = 1'b1; beats = 0; d0 = done_cnt; rd0 = reads_total;
    start_block(2, 0);
    n = 0;
    while (w_go_out && n < 1000) begin
      n++;
      tick(1);
    end
    check(n == 255, "timeout_go_cycles", 32'(n), 32'd255);
    check(err_timeout == 1'b1, "timeout_flag", 32'(err_timeout), 32'd1);
    wait_idle(50, "timeout_idle");
    tick(2);
    check(err_timeout == 1'b1 && !w_go_out, "timeout_sticky", 32'({err_timeout, w_go_out}), 32'h2);
    check(done_cnt == d0, "timeout_no_done", 32'(done_cnt - d0), 32'd0);
    check(reads_total == rd0, "timeout_no_reads", 32'(reads_total - rd0), 32'd0);
    hold_rdy = 1'b0;

    // Abort while holding idx 30
    beats = 0; d0 = done_cnt;
    stall_idx = 30; stall_left = 1000;
    start_block(3, 30);
    check(err_timeout == 1'b0, "err_cleared_on_start", 32'(err_timeout), 32'd0);
    wait_beat(30, 600, "abort_reach_idx30");
    abort = 1'b1;
    rd0 = reads_total;
    tick(1);
    abort = 1'b0;
    check(round_valid == 1'b0, "abort_valid_drop", 32'(round_valid), 32'd0);
    wait_idle(50, "abort_idle");
    tick(2);
    stall_left = 0;
    check(reads_total == rd0, "abort_no_reads", 32'(reads_total - rd0), 32'd0);
    check(done_cnt == d0, "abort_no_done", 32'(done_cnt - d0), 32'd0);
    check(beats == 30 && exp_q.size() == 0, "abort_beats", 32'(beats), 32'd30);

    beats = 0; d0 = done_cnt;
    start_block(4, 64);
    wait_idle(600, "post_abort_complete");
    tick(2);
    check(got_w[0] == 32'h0400A5C3, "post_abort_w0", got_w[0], 32'h0400A5C3);
    check(beats == 64 && done_cnt - d0 == 1, "post_abort_block", 32'(beats), 32'd64);

    // Reset at idx 40
    beats = 0; d0 = done_cnt;
    stall_idx = 40; stall_left = 1000;
    start_block(5, 40);
    wait_beat(40, 600, "reset_reach_idx40");
    reset = 1'b1;
    tick(1);
    check_zero("midblock_reset_outputs");
    reset = 1'b0;
    stall_left = 0;
    tick(2);
    check(beats == 40 && exp_q.size() == 0, "reset_beats", 32'(beats), 32'd40);
    beats = 0;
    start_block(6, 64);
    wait_idle(600, "post_reset_complete");
    tick(2);
    check(beats == 64 && exp_q.size() == 0, "post_reset_beats", 32'(beats), 32'd64);
    check(done_cnt - d0 == 1, "post_reset_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back blocks, plus a start while busy
    beats = 0; d0 = done_cnt;
    start_block(7, 64);
    n = 0;
    while (!blk_done && n < 600) begin
      tick(1);
      n++;
    end
    check(n < 600, "b2b_first_done", 32'(n), 32'd600);
    tick(1);
    start_block(8, 64);
    tick(50);
    blk_start = 1'b1;
    tick(1);
    blk_start = 1'b0;
    check(busy == 1'b1, "b2b_busy_ignore", 32'(busy), 32'd1);
    wait_idle(600, "b2b_second_complete");
    tick(3);
    check(beats == 128 && exp_q.size() == 0, "b2b_beats", 32'(beats), 32'd128);
    check(done_cnt - d0 == 2, "b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check(busy == 1'b0 && !w_go_out, "b2b_idle_after", 32'({busy, w_go_out}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
